// File: rtl/sobel_window_gen.sv
// 3x3 neighbourhood window generator for a raster-order 8-bit pixel stream.
// Two line buffers hold the previous two rows; a 3x3 register array shifts
// left on every accepted pixel. Fully streaming, no backpressure.
module sobel_window_gen #(
    parameter int unsigned IMG_WIDTH  = 512,
    parameter int unsigned IMG_HEIGHT = 512
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic [7:0]  pixel_in,
    input  logic        pixel_in_valid,
    input  logic        sof_in,
    output logic [71:0] window_data,
    output logic        window_valid,
    output logic        frame_done
);

    localparam int unsigned CW = $clog2(IMG_WIDTH);
    localparam int unsigned RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0] col_q, col_d, col_cur;
    logic [RW-1:0] row_q, row_d, row_cur;
    logic [71:0]   win_q, win_d;
    logic          valid_q, valid_d;
    logic          done_q, done_d;

    // lb0 holds row r-1, lb1 holds row r-2; never cleared (rows 0-1 are masked)
    logic [7:0] lb0_mem [IMG_WIDTH];
    logic [7:0] lb1_mem [IMG_WIDTH];
    logic [7:0] lb0_rd, lb1_rd;

    // Position of the current pixel; a qualified sof forces (0,0)
    always_comb begin
        col_cur = col_q;
        row_cur = row_q;
        if (pixel_in_valid && sof_in) begin
            col_cur = '0;
            row_cur = '0;
        end
    end

    assign lb0_rd = lb0_mem[col_cur];
    assign lb1_rd = lb1_mem[col_cur];

    // Line buffer update: read-before-write, lb0 column shifts into lb1
    always_ff @(posedge clk) begin
        if (pixel_in_valid) begin
            lb1_mem[col_cur] <= lb0_mem[col_cur];
            lb0_mem[col_cur] <= pixel_in;
        end
    end

    // Next-state: counters, window shift, valid and frame-done strobes
    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        win_d   = win_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        if (pixel_in_valid) begin
            if (col_cur == COL_LAST) begin
                col_d = '0;
                row_d = (row_cur == ROW_LAST) ? '0 : row_cur + RW'(1);
            end else begin
                col_d = col_cur + CW'(1);
                row_d = row_cur;
            end
            // byte i = row*3+col; shift each row left, new column on the right
            win_d[7:0]   = win_q[15:8];
            win_d[15:8]  = win_q[23:16];
            win_d[23:16] = lb1_rd;
            win_d[31:24] = win_q[39:32];
            win_d[39:32] = win_q[47:40];
            win_d[47:40] = lb0_rd;
            win_d[55:48] = win_q[63:56];
            win_d[63:56] = win_q[71:64];
            win_d[71:64] = pixel_in;
            valid_d = (row_cur >= RW'(2)) && (col_cur >= CW'(2));
            done_d  = (row_cur == ROW_LAST) && (col_cur == COL_LAST);
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            col_q   <= '0;
            row_q   <= '0;
            win_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            win_q   <= win_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign window_data  = win_q;
    assign window_valid = valid_q;
    assign frame_done   = done_q;

endmodule

// File: doc/sobel_window_gen.md
Name: sobel_window_gen

Overview:
Upstream neighbour of the Sobel gradient stage. Accepts a raster-order 8-bit grayscale pixel stream and builds a 3x3 neighbourhood window using two line buffers and a 3x3 register array. It emits a packed 72-bit window plus a valid strobe, which connect directly to the gradient stage's data/valid inputs. No backpressure: the pipeline is fully streaming.

Parameters:
IMG_WIDTH, 512, pixels per line (must be >= 3)
IMG_HEIGHT, 512, lines per frame (must be >= 3)

Ports:
clk  input  1  rising-edge clock
rstN  input  1  asynchronous active-low reset
pixel_in  input  8  unsigned grayscale pixel, raster order
pixel_in_valid  input  1  pixel_in is accepted this cycle
sof_in  input  1  start of frame; qualified by pixel_in_valid; forces that pixel to row 0, col 0
window_data  output  72  packed 3x3 window; byte i = window_data[i*8+:8], i = row*3+col, i=0 top-left, i=8 bottom-right (newest pixel)
window_valid  output  1  window_data is valid this cycle
frame_done  output  1  one-cycle pulse coincident with the last window of a frame

Behaviour:
- Reset (rstN low, asynchronous): col/row counters = 0; window registers = 0; window_data = 0; window_valid = 0; frame_done = 0. Line buffer RAM contents are not cleared. They need no clearing because rows 0-1 never produce output.
- Counters: col 0..IMG_WIDTH-1 and row 0..IMG_HEIGHT-1, each $clog2 width. They advance only on accepted pixels (pixel_in_valid=1).
  - col wraps to 0 at IMG_WIDTH-1 and row increments at the same time.
  - row wraps to 0 after IMG_HEIGHT-1 / IMG_WIDTH-1, so the next frame starts automatically without sof_in.
- sof_in: when sof_in=1 with pixel_in_valid=1, the pixel is treated as (row 0, col 0) whatever the counter state; the counters then continue from col 1. sof_in without pixel_in_valid is ignored. A sof_in mid-frame abandons the current frame, and no frame_done is produced for it.
- Line buffers: lb0 holds row r-1 and lb1 holds row r-2, each IMG_WIDTH x 8. On an accepted pixel at column c:
  - read lb1[c] and lb0[c];
  - write lb1[c] <= lb0[c] and lb0[c] <= pixel_in in the same cycle (read-before-write).
  - The block may use registers or inferred RAM, but the read-before-write semantics are required.
- Window shift: on an accepted pixel, every window row shifts one column left (col0 <= col1, col1 <= col2). The new right column is top = lb1[c], mid = lb0[c], bottom = pixel_in.
- Output validity: window_valid <= pixel_in_valid && row >= 2 && col >= 2, evaluated for the accepted pixel.
  - Latency is 1 cycle from the accepted pixel to window_valid/window_data.
  - A window never straddles a line, because col >= 2 guarantees the 3 columns belong to the current line.
  - Each frame produces exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows.
- Idle cycles (pixel_in_valid=0): counters, window and line buffers hold; window_valid=0 the next cycle; window_data holds its last value.
- frame_done = 1 in the same cycle as window_valid for the pixel at (IMG_HEIGHT-1, IMG_WIDTH-1); otherwise 0.
- Reset asserted mid-frame: outputs clear immediately. After release, the next accepted pixel is (0,0). Stale line-buffer data is masked by the row >= 2 rule.

Test Plan:
- IMG_WIDTH=4, IMG_HEIGHT=4; stream 16 back-to-back pixels with values 1..16, sof_in on the first -> exactly 4 window_valid pulses. The first, one cycle after pixel 11, has bytes i0..i8 = 1,2,3,5,6,7,9,10,11: window_data[7:0]=1, window_data[71:64]=11.
- Same frame, second window (after pixel 12) -> bytes 2,3,4,6,7,8,10,11,12. The fourth window (after pixel 16) -> bytes 6,7,8,10,11,12,14,15,16, with frame_done=1 in that cycle only.
- Same frame with pixel_in_valid deasserted for 3 cycles between every pixel -> identical 4 windows in the same order. window_valid is never high in a cycle not following an accepted pixel.
- Two consecutive 4x4 frames, second frame values 101..116, no sof_in on the second frame -> the second frame's first window is 101,102,103,105,106,107,109,110,111. Exactly 8 windows and 2 frame_done pulses in total.
- Assert rstN low after pixel 10 of a frame, release, then send a new 16-pixel frame -> window_valid=0 and window_data=0 during reset, no output from the aborted frame, and the new frame gives correct 4 windows.
- Send sof_in with pixel 6 of a frame (values 1..5, then 1..16) -> windows correspond to the restarted frame only (first = 1,2,3,5,6,7,9,10,11), with one frame_done.
